// File: rtl/fcmp_sched.sv
// fcmp_sched: NREQ requesters share one two-stage float-compare pipe (feq/flt/fle), round-robin arbitrated.
// Define FCMP_SCHED_PERF_EN to add the perf_grants/perf_stalls/perf_illegal counter ports.
module fcmp_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [2*NREQ-1:0]   req_op,
  input  logic [32*NREQ-1:0]  req_x1,
  input  logic [32*NREQ-1:0]  req_x2,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_data
`ifdef FCMP_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_grants,
  output logic [31:0]         perf_stalls,
  output logic [15:0]         perf_illegal
`endif
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic              r_s1_valid;
  logic [1:0]        r_s1_op;
  logic [31:0]       r_s1_x1;
  logic [31:0]       r_s1_x2;
  logic [IDW-1:0]    r_s1_id;
  logic              r_s2_valid;
  logic [IDW-1:0]    r_s2_id;
  logic              r_s2_flag;
  logic [IDW-1:0]    r_rr_ptr;

  logic              w_adv1;
  logic              w_adv2;
  logic              w_gnt_any;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW:0]      w_sum;
  logic [IDW:0]      w_ptr_inc;
  logic [IDW-1:0]    w_next_ptr;
  logic [2*NREQ-1:0] w_rot;
  logic [1:0]        w_op;
  logic [31:0]       w_x1;
  logic [31:0]       w_x2;
  logic              w_zero;
  logic              w_sdiff;
  logic              w_mlt;
  logic              w_mle;
  logic              w_flag;

  assign w_adv2 = !r_s2_valid || rsp_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;

  // Rotate the request vector so bit k means requester (rr_ptr+k) mod NREQ; lowest k wins.
  always_comb begin
    w_rot     = {req_valid, req_valid} >> r_rr_ptr;
    w_gnt_any = 1'b0;
    w_sum     = '0;
    if (!rst && w_adv1) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (w_rot[k]) begin
          w_gnt_any = 1'b1;
          w_sum     = {1'b0, r_rr_ptr} + (IDW+1)'(k);
        end
      end
    end
    w_gnt_id = (w_sum >= NREQ_W) ? IDW'(w_sum - NREQ_W) : IDW'(w_sum);
  end

  assign w_ptr_inc  = {1'b0, w_gnt_id} + (IDW+1)'(1);
  assign w_next_ptr = (w_ptr_inc == NREQ_W) ? '0 : IDW'(w_ptr_inc);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_gnt_any && (w_gnt_id == IDW'(gi));
    end
  endgenerate

  always_comb begin
    w_op = '0;
    w_x1 = '0;
    w_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_op = req_op[2*i +: 2];
        w_x1 = req_x1[32*i +: 32];
        w_x2 = req_x2[32*i +: 32];
      end
    end
  end

  // Compare on S1 contents; denormals and zeros all collapse to "zero" when both exponents are 0.
  assign w_zero  = (r_s1_x1[30:23] == 8'd0) && (r_s1_x2[30:23] == 8'd0);
  assign w_sdiff = r_s1_x1[31] ^ r_s1_x2[31];
  assign w_mlt   = r_s1_x1[30:0] <  r_s1_x2[30:0];
  assign w_mle   = r_s1_x1[30:0] <= r_s1_x2[30:0];

  always_comb begin
    w_flag = 1'b0;
    case (r_s1_op)
      2'b00:   w_flag = w_zero || (r_s1_x1 == r_s1_x2);
      2'b01:   w_flag = w_zero ? 1'b0 : (w_sdiff ? r_s1_x1[31] : (r_s1_x1[31] ^ w_mlt));
      2'b10:   w_flag = w_zero ? 1'b1 : (w_sdiff ? r_s1_x1[31] : (r_s1_x1[31] ^ w_mle));
      default: w_flag = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_id    <= '0;
      r_s2_flag  <= 1'b0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_id   <= r_s1_id;
          r_s2_flag <= w_flag;
        end
      end
      if (w_adv1) begin
        r_s1_valid <= w_gnt_any;
      end
      if (w_gnt_any) begin
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_gnt_any) begin
      r_s1_op <= w_op;
      r_s1_x1 <= w_x1;
      r_s1_x2 <= w_x2;
      r_s1_id <= w_gnt_id;
    end
  end

  assign rsp_valid = r_s2_valid;
  assign rsp_id    = r_s2_id;
  assign rsp_data  = {31'b0, r_s2_flag};

`ifdef FCMP_SCHED_PERF_EN
  logic [31:0] r_perf_grants;
  logic [31:0] r_perf_stalls;
  logic [15:0] r_perf_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_grants  <= '0;
      r_perf_stalls  <= '0;
      r_perf_illegal <= '0;
    end else begin
      if (w_gnt_any) begin
        r_perf_grants <= r_perf_grants + 32'd1;
      end
      if (r_s2_valid && !rsp_ready) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
      if (w_gnt_any && (w_op == 2'b11)) begin
        r_perf_illegal <= r_perf_illegal + 16'd1;
      end
    end
  end

  assign perf_grants  = r_perf_grants;
  assign perf_stalls  = r_perf_stalls;
  assign perf_illegal = r_perf_illegal;
`endif

endmodule
